// File: rtl/onchip_arb_pkg.sv
// Shared types and default sizes for the two-requester on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_WORDS = 5320;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle joining the two requesters, the arbiter and the single-port RAM.
interface onchip_mem_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [BE_W-1:0]   m0_be;
    logic              m0_write;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [BE_W-1:0]   m1_be;
    logic              m1_write;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_addr, m0_be, m0_write, m0_wdata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_req, m1_addr, m1_be, m1_write, m1_wdata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    // Requesters plus RAM side
    modport master (
        output m0_req, m0_addr, m0_be, m0_write, m0_wdata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_req, m1_addr, m1_be, m1_write, m1_wdata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/onchip_arb_rr2.sv
// Two-way round-robin pick; the requester not granted last wins a tie.
module onchip_arb_rr2
    import onchip_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  req_id_t    i_grant_id,
    output req_id_t    o_pick
);
    req_id_t r_last;

    // Starts as 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_grant_id;
        end
    end

    always_comb begin
        case (i_req)
            2'b01:   o_pick = 1'b0;
            2'b10:   o_pick = 1'b1;
            default: o_pick = ~r_last;
        endcase
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter for a single-port on-chip RAM with grant lock and 1-cycle reads.
// Optional out-of-range address check: define ONCHIP_ARB_ADDR_CHECK_EN.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave bus,
    output logic                err_oor
);
    localparam int BE_W = DATA_W / 8;

    logic              r_rst_meta, r_rst_sync;
    arb_state_e        r_state, w_state_nxt;
    req_id_t           r_owner, w_owner_nxt, w_pick;
    logic              r_rdv;
    req_id_t           r_rdv_id;
    logic [1:0]        w_req;
    logic              w_own_req, w_own_write, w_own_lock, w_other_req;
    logic              w_active, w_accept, w_mem_write_en;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata, w_rdata;

    // Assert asynchronously, release on the second clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_req = {bus.m1_req, bus.m0_req};

    always_comb begin
        if (r_owner) begin
            w_own_req   = bus.m1_req;
            w_own_write = bus.m1_write;
            w_own_lock  = bus.m1_lock;
            w_addr      = bus.m1_addr;
            w_be        = bus.m1_be;
            w_wdata     = bus.m1_wdata;
            w_other_req = bus.m0_req;
        end else begin
            w_own_req   = bus.m0_req;
            w_own_write = bus.m0_write;
            w_own_lock  = bus.m0_lock;
            w_addr      = bus.m0_addr;
            w_be        = bus.m0_be;
            w_wdata     = bus.m0_wdata;
            w_other_req = bus.m1_req;
        end
    end

    assign w_active = r_rst_sync && (r_state != IDLE);
    assign w_accept = w_active && w_own_req;

    onchip_arb_rr2 u_rr2 (
        .clk        (clk),
        .rst_n      (r_rst_sync),
        .i_req      (w_req),
        .i_update   (w_accept),
        .i_grant_id (r_owner),
        .o_pick     (w_pick)
    );

    // An idle owner hands over at once; a locked owner keeps the grant even when idle
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = SERVE;
                    w_owner_nxt = w_pick;
                end
            end
            SERVE, LOCK: begin
                if (w_accept && w_own_lock) begin
                    w_state_nxt = LOCK;
                end else if (w_accept || r_state == SERVE) begin
                    w_state_nxt = SERVE;
                    if (w_other_req) begin
                        w_owner_nxt = ~r_owner;
                    end else if (!w_own_req) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_rdv    <= 1'b0;
            r_rdv_id <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rdv    <= w_accept && !w_own_write;
            r_rdv_id <= r_owner;
        end
    end

`ifdef ONCHIP_ARB_ADDR_CHECK_EN
    logic w_oor, r_rd_zero, r_err_oor;

    assign w_oor = int'(w_addr) >= NUM_WORDS;

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_rd_zero <= 1'b0;
            r_err_oor <= 1'b0;
        end else begin
            r_rd_zero <= w_oor;
            r_err_oor <= r_err_oor | (w_accept & w_oor);
        end
    end

    assign w_mem_write_en = w_own_write && !w_oor;
    assign w_rdata        = r_rd_zero ? '0 : bus.mem_readdata;
    assign err_oor        = r_err_oor;
`else
    assign w_mem_write_en = w_own_write;
    assign w_rdata        = bus.mem_readdata;
    assign err_oor        = 1'b0;
`endif

    assign bus.mem_address    = w_addr;
    assign bus.mem_byteenable = w_be;
    assign bus.mem_writedata  = w_wdata;
    assign bus.mem_chipselect = w_accept;
    assign bus.mem_write      = w_accept && w_mem_write_en;
    assign bus.mem_clken      = (NUM_WORDS > 0);

    assign bus.m0_waitrequest   = !(w_active && r_owner == 1'b0);
    assign bus.m1_waitrequest   = !(w_active && r_owner == 1'b1);
    assign bus.m0_readdata      = w_rdata;
    assign bus.m1_readdata      = w_rdata;
    assign bus.m0_readdatavalid = r_rdv && (r_rdv_id == 1'b0);
    assign bus.m1_readdatavalid = r_rdv && (r_rdv_id == 1'b1);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: directed vectors, a RAM model, and a read-response monitor.
module tb_onchip_mem_arbiter;
   import onchip_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   logic errOor;
   int   nChecks = 0;
   int   nPass = 0;
   int   cycleCount = 0;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t expQ[$];

   logic [31:0] ram [0:8191];
   logic [31:0] ramQ;

   onchip_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

   onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .NUM_WORDS(5320)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .err_oor (errOor)
   );

   // Free-running 10-unit clock and a cycle counter used to time read responses
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single-port RAM with one-cycle read latency and byte-enabled writes
   always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_clken) begin
         ramQ <= ram[bus.mem_address];
         if (bus.mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] = bus.mem_writedata[8*b +: 8];
            end
         end
      end
   end

   assign bus.mem_readdata = ramQ;

   task automatic applyStimulus(input int port, input logic req, input logic write,
                                input logic [12:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic lock);
      if (port == 0) begin
         bus.m0_req = req; bus.m0_write = write; bus.m0_addr = addr;
         bus.m0_be = be; bus.m0_wdata = wdata; bus.m0_lock = lock;
      end else begin
         bus.m1_req = req; bus.m1_write = write; bus.m1_addr = addr;
         bus.m1_be = be; bus.m1_wdata = wdata; bus.m1_lock = lock;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic expectRead(input int id, input logic [31:0] data);
      expQ.push_back('{id, data, cycleCount + 1});
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Pops the oldest expected read whenever either requester sees readdatavalid
   task automatic checkResponse(input int port, input logic [31:0] data);
      exp_t e;
      nChecks++;
      if (expQ.size() == 0) begin
         $display("[TB] FAIL rd_resp: got valid on m%0d data 0x%0h at cycle %0d, expected no response",
                  port, data, cycleCount);
      end else begin
         e = expQ.pop_front();
         if (e.id == port && e.data === data && e.cyc == cycleCount) nPass++;
         else $display("[TB] FAIL rd_resp: got m%0d 0x%0h cycle %0d, expected m%0d 0x%0h cycle %0d",
                       port, data, cycleCount, e.id, e.data, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.m0_readdatavalid === 1'b1) checkResponse(0, bus.m0_readdata);
      if (bus.m1_readdatavalid === 1'b1) checkResponse(1, bus.m1_readdata);
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish by time 100000, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
      ram[16'h0010] = 32'h1234_5678;
      ram[16'h0020] = 32'h55AA_0020;
      ram[16'h0100] = 32'hDEAD_0100;
      ram[5320]     = 32'hFFFF_FFFF;
      ramQ = 32'h0;
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      nextCycle();
      nextCycle();

      // Requests during reset must be stalled and the RAM left untouched
      applyStimulus(0, 1, 1, 13'h10, 4'hF, 32'h0, 0);
      applyStimulus(1, 1, 0, 13'h20, 4'hF, 32'h0, 0);
      sample();
      checkOutput("rst_wait0", bus.m0_waitrequest, 1);
      checkOutput("rst_wait1", bus.m1_waitrequest, 1);
      checkOutput("rst_cs", bus.mem_chipselect, 0);
      checkOutput("rst_wr", bus.mem_write, 0);
      checkOutput("rst_err", errOor, 0);

      // Release: two sync edges, one IDLE edge, then m0's read is accepted
      nextCycle();
      reset_n = 1'b1;
      applyStimulus(0, 1, 0, 13'h10, 4'hF, 32'h0, 0);
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      checkOutput("sync_wait_e0", bus.m0_waitrequest, 1);
      nextCycle(); sample();
      checkOutput("sync_wait_e1", bus.m0_waitrequest, 1);
      nextCycle(); sample();
      checkOutput("sync_wait_e2", bus.m0_waitrequest, 1);
      nextCycle(); sample();
      checkOutput("rd_wait0", bus.m0_waitrequest, 0);
      checkOutput("rd_addr", bus.mem_address, 32'h10);
      checkOutput("rd_cs", bus.mem_chipselect, 1);
      checkOutput("rd_wr", bus.mem_write, 0);
      checkOutput("rd_clken", bus.mem_clken, 1);
      expectRead(0, 32'h1234_5678);
      nextCycle();
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      checkOutput("idle_cs", bus.mem_chipselect, 0);
      nextCycle();

      // m1 byte-lane write then readback: only byte 1 lands
      applyStimulus(1, 1, 1, 13'h5, 4'b0010, 32'hAABB_CCDD, 0);
      sample();
      checkOutput("be_idle_wait1", bus.m1_waitrequest, 1);
      nextCycle(); sample();
      checkOutput("be_wait1", bus.m1_waitrequest, 0);
      checkOutput("be_mask", bus.mem_byteenable, 32'h2);
      checkOutput("be_wr", bus.mem_write, 1);
      checkOutput("be_addr", bus.mem_address, 32'h5);
      nextCycle();
      applyStimulus(1, 1, 0, 13'h5, 4'hF, 32'h0, 0);
      sample();
      checkOutput("rb_cs", bus.mem_chipselect, 1);
      expectRead(1, 32'h0000_CC00);
      nextCycle();
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      nextCycle();

      // Both requesters write continuously: strict alternation starting with m0
      applyStimulus(0, 1, 1, 13'h40, 4'hF, 32'h0000_0A00, 0);
      applyStimulus(1, 1, 1, 13'h80, 4'hF, 32'h0000_0B00, 0);
      sample();
      checkOutput("alt_idle_w0", bus.m0_waitrequest, 1);
      checkOutput("alt_idle_w1", bus.m1_waitrequest, 1);
      for (int k = 0; k < 4; k++) begin
         nextCycle(); sample();
         checkOutput($sformatf("alt%0d_w0", k), bus.m0_waitrequest, (k % 2 == 0) ? 0 : 1);
         checkOutput($sformatf("alt%0d_w1", k), bus.m1_waitrequest, (k % 2 == 0) ? 1 : 0);
         checkOutput($sformatf("alt%0d_addr", k), bus.mem_address, (k % 2 == 0) ? 32'h40 : 32'h80);
         checkOutput($sformatf("alt%0d_wd", k), bus.mem_writedata, (k % 2 == 0) ? 32'h0A00 : 32'h0B00);
      end
      nextCycle();
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      checkOutput("alt_done_cs", bus.mem_chipselect, 0);
      nextCycle();

      // m1 locked read-modify-write-read at 0x100; m0 stalled for all three
      applyStimulus(1, 1, 0, 13'h100, 4'hF, 32'h0, 1);
      sample();
      checkOutput("lk_idle_w1", bus.m1_waitrequest, 1);
      nextCycle();
      applyStimulus(0, 1, 0, 13'h10, 4'hF, 32'h0, 0);
      sample();
      checkOutput("lkA_w0", bus.m0_waitrequest, 1);
      checkOutput("lkA_w1", bus.m1_waitrequest, 0);
      expectRead(1, 32'hDEAD_0100);
      nextCycle();
      applyStimulus(1, 1, 1, 13'h100, 4'hF, 32'hDEAD_0101, 1);
      sample();
      checkOutput("lkB_w0", bus.m0_waitrequest, 1);
      checkOutput("lkB_w1", bus.m1_waitrequest, 0);
      checkOutput("lkB_wr", bus.mem_write, 1);
      nextCycle();
      applyStimulus(1, 1, 0, 13'h100, 4'hF, 32'h0, 0);
      sample();
      checkOutput("lkC_w0", bus.m0_waitrequest, 1);
      checkOutput("lkC_w1", bus.m1_waitrequest, 0);
      expectRead(1, 32'hDEAD_0101);
      nextCycle();
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      checkOutput("lkD_w0", bus.m0_waitrequest, 0);
      checkOutput("lkD_addr", bus.mem_address, 32'h10);
      expectRead(0, 32'h1234_5678);
      nextCycle();
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      nextCycle();

      // Reset right after a locked read accept: no response, lock forgotten
      applyStimulus(0, 1, 0, 13'h10, 4'hF, 32'h0, 1);
      sample();
      nextCycle(); sample();
      checkOutput("rs_acc_w0", bus.m0_waitrequest, 0);
      nextCycle();
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      applyStimulus(1, 1, 0, 13'h20, 4'hF, 32'h0, 0);
      sample();
      checkOutput("rs_rdv0", bus.m0_readdatavalid, 0);
      checkOutput("rs_wait1", bus.m1_waitrequest, 1);
      checkOutput("rs_cs", bus.mem_chipselect, 0);
      nextCycle();
      reset_n = 1'b1;
      sample();
      nextCycle(); sample();
      nextCycle(); sample();
      checkOutput("rs_idle_w1", bus.m1_waitrequest, 1);
      nextCycle(); sample();
      checkOutput("rs_grant_w1", bus.m1_waitrequest, 0);
      checkOutput("rs_addr", bus.mem_address, 32'h20);
      expectRead(1, 32'h55AA_0020);
      nextCycle();
      applyStimulus(1, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      nextCycle();

`ifdef ONCHIP_ARB_ADDR_CHECK_EN
      // Out-of-range write is dropped, read returns zero, error sticks
      applyStimulus(0, 1, 1, 13'd5320, 4'hF, 32'h1111_1111, 0);
      sample();
      nextCycle(); sample();
      checkOutput("oor_cs", bus.mem_chipselect, 1);
      checkOutput("oor_wr", bus.mem_write, 0);
      nextCycle();
      applyStimulus(0, 1, 0, 13'd5320, 4'hF, 32'h0, 0);
      sample();
      checkOutput("oor_err", errOor, 1);
      expectRead(0, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 13'h0, 4'h0, 32'h0, 0);
      sample();
      checkOutput("oor_err_hold", errOor, 1);
      nextCycle();
`else
      checkOutput("err_tied", errOor, 0);
`endif

      nextCycle(); sample();
      checkOutput("sb_drain", 32'(expQ.size()), 0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
